// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side and i2c-core-side signals of the transaction arbiter.
// The slave modport is the arbiter; the master modport is everything around it.
interface i2c_txn_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [7*NUM_REQ-1:0]  req_slave_address;
    logic [NUM_REQ-1:0]    req_read_write;
    logic [8*NUM_REQ-1:0]  req_register_address;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;
    logic                  rsp_timeout;
    logic                  i2c_en;
    logic [6:0]            i2c_slave_address;
    logic                  i2c_read_write;
    logic [7:0]            i2c_register_address;
    logic [31:0]           i2c_data;
    logic [31:0]           i2c_rdata;
    logic                  i2c_done;

    // Handshake: a request is taken on the cycle req_ready[k] is seen high while
    // req_valid[k] is high; the requester holds valid and fields until then.
    // rsp_valid[k] is a one-cycle strobe with no back-pressure.
    modport slave (
        input  req_valid, req_slave_address, req_read_write, req_register_address,
               req_data, i2c_rdata, i2c_done,
        output req_ready, rsp_valid, rsp_data, rsp_timeout, i2c_en,
               i2c_slave_address, i2c_read_write, i2c_register_address, i2c_data
    );

    modport master (
        output req_valid, req_slave_address, req_read_write, req_register_address,
               req_data, i2c_rdata, i2c_done,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout, i2c_en,
               i2c_slave_address, i2c_read_write, i2c_register_address, i2c_data
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one i2c master core between NUM_REQ requesters:
// accept, hold fields for SETUP_CYCLES, pulse enable, wait for done or timeout, respond.
module i2c_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    i2c_txn_arbiter_if.slave    bus,
    output logic                busy,
    output logic [2:0]          state_dbg
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0]      SETUP_LAST = SW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0]      WAIT_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]      GRANT_INIT = GW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE        = NUM_REQ'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] grant;
    logic [GW-1:0] pick;
    logic [SW-1:0] setup_cnt;
    logic [TW-1:0] wait_cnt;

    // Scan offsets from farthest to nearest so the requester just after
    // last_grant is assigned last and therefore wins.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [GW-1:0] last);
        logic [GW-1:0] sel;
        int idx;
        sel = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (valid[idx]) sel = GW'(idx);
        end
        return sel;
    endfunction

    always_comb pick = rr_pick(bus.req_valid, last_grant);

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= IDLE;
            last_grant               <= GRANT_INIT;
            grant                    <= '0;
            setup_cnt                <= '0;
            wait_cnt                 <= '0;
            busy                     <= 1'b0;
            bus.req_ready            <= '0;
            bus.rsp_valid            <= '0;
            bus.rsp_data             <= '0;
            bus.rsp_timeout          <= 1'b0;
            bus.i2c_en               <= 1'b0;
            bus.i2c_slave_address    <= '0;
            bus.i2c_read_write       <= 1'b0;
            bus.i2c_register_address <= '0;
            bus.i2c_data             <= '0;
        end else begin
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            bus.i2c_en    <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        grant                    <= pick;
                        bus.req_ready            <= ONE << pick;
                        bus.i2c_slave_address    <= bus.req_slave_address[7*pick +: 7];
                        bus.i2c_read_write       <= bus.req_read_write[pick];
                        bus.i2c_register_address <= bus.req_register_address[8*pick +: 8];
                        bus.i2c_data             <= bus.req_data[32*pick +: 32];
                        setup_cnt                <= '0;
                        busy                     <= 1'b1;
                        state                    <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_cnt == SETUP_LAST) state <= START;
                    else setup_cnt <= setup_cnt + 1'b1;
                end
                START: begin
                    bus.i2c_en <= 1'b1;
                    wait_cnt   <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the terminal-count cycle still counts as success.
                    if (bus.i2c_done) begin
                        bus.rsp_data    <= bus.i2c_read_write ? bus.i2c_rdata : 32'h0;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_valid   <= ONE << grant;
                        state           <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        bus.rsp_data    <= 32'h0;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_valid   <= ONE << grant;
                        state           <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= grant;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
Shares the single i2c master core between NUM_REQ independent requesters. Each requester presents a slave address, read/write flag, register address and 32-bit write data with a valid/ready handshake. The arbiter picks one requester round-robin and drives the core's address and data inputs. It pulses the core's enable once per transaction, waits for completion or timeout, and returns the response to the granted requester. It sits between the system-side register and DMA clients and the i2c core's ext_* interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SETUP_CYCLES, 2, cycles the i2c_* fields are held stable before the i2c_en pulse (>=1)
TIMEOUT_CYCLES, 4096, cycles in WAIT before the transaction is aborted (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot; request accepted this cycle
req_slave_address  in  7*NUM_REQ  packed; requester k at [7k+6:7k]
req_read_write  in  NUM_REQ  1 = read, 0 = write
req_register_address  in  8*NUM_REQ  packed; requester k at [8k+7:8k]
req_data  in  32*NUM_REQ  packed write data; requester k at [32k+31:32k]
rsp_valid  out  NUM_REQ  one-hot; single-cycle response strobe
rsp_data  out  32  read data; 0 for writes and timeouts
rsp_timeout  out  1  qualifies rsp_valid; 1 = aborted by timeout
busy  out  1  high in every state except IDLE
i2c_en  out  1  single-cycle start pulse to the core's en
i2c_slave_address  out  7  to the core's ext_slave_address_in
i2c_read_write  out  1  to the core's ext_read_write_in
i2c_register_address  out  8  to the core's ext_register_address_in
i2c_data  out  32  to the core's ext_data_in
i2c_rdata  in  32  from the core's ext_data_out
i2c_done  in  1  single-cycle completion pulse from the core

Behaviour:
- All outputs are registered. On reset every output is 0, the state is IDLE, and last_grant = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, SETUP, START, WAIT, RESP.
- IDLE: if req_valid is nonzero, select the first set bit searching upward from last_grant+1 (mod NUM_REQ).
  - Latch that requester's fields and index g.
  - Assert req_ready[g] for exactly that cycle, then go to SETUP with the counter at 0.
  - req_ready is never asserted outside IDLE. Requesters hold valid and fields until they see ready.
- SETUP: i2c_* fields show the latched values (held through RESP). Go to START when the counter reaches SETUP_CYCLES-1.
- START: i2c_en=1 for this cycle only. Go to WAIT with the timeout counter at 0.
- WAIT: i2c_en=0.
  - On i2c_done, capture rsp_data = i2c_rdata if read, else 0. Set rsp_timeout=0 and go to RESP.
  - Otherwise, if the counter equals TIMEOUT_CYCLES-1, set rsp_data=0, rsp_timeout=1 and go to RESP.
  - i2c_done in the same cycle as the timeout terminal count: done wins.
- RESP: rsp_valid[g]=1 for one cycle, with rsp_data and rsp_timeout stable. Set last_grant=g and go to IDLE.
- rsp_data and rsp_timeout hold their values until the next RESP.
- Latency:
  - Accept to i2c_en = SETUP_CYCLES+1 cycles.
  - i2c_done to rsp_valid = 1 cycle.
  - Minimum gap between two accepts = SETUP_CYCLES+4 cycles.
- i2c_done outside WAIT is ignored.
- Changes to req_* fields after acceptance do not affect the latched transaction.
- Multiple requesters valid: strict round-robin, so no requester waits more than NUM_REQ-1 transactions.
- Reset mid-transaction: return to IDLE immediately, no rsp_valid, i2c_en=0 from the next cycle.

Test Plan:
- Single write: requester 0 presents slave 7'h63, write, register 8'h0b, data 32'h58ae1234.
  - Expect req_ready[0] 1 cycle.
  - Expect i2c_* fields stable, then i2c_en for 1 cycle, 3 cycles after accept.
  - Model i2c_done 100 cycles later; expect rsp_valid=4'b0001, rsp_data=0, rsp_timeout=0.
- Single read: requester 2 presents 7'h63, read, register 8'h0f.
  - Model returns i2c_rdata=32'h5834_12ae with i2c_done.
  - Expect rsp_valid=4'b0100, rsp_data=32'h583412ae.
- Fairness: all four req_valid held high for 8 transactions from reset.
  - Expect grant order 0,1,2,3,0,1,2,3.
  - Each requester's own fields appear on i2c_*.
- Timeout: TIMEOUT_CYCLES=16, requester 1 issues a read to 7'h6b and i2c_done never comes.
  - Expect rsp_valid=4'b0010, rsp_timeout=1, rsp_data=0, exactly 16 cycles after i2c_en.
  - Also drive i2c_done on the terminal-count cycle; expect rsp_timeout=0.
- Spurious done: pulse i2c_done in IDLE and SETUP.
  - Expect no rsp_valid and the state sequence unchanged.
- Reset during WAIT: assert rst for 1 cycle.
  - Expect busy=0 and all outputs 0 the next cycle, no rsp_valid.
  - The next request from requester 0 is granted normally.
